// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: shares the single L2 request port between the L1I
// and L1D miss paths, one transaction outstanding at a time.
// Winner's tag/index/op/wdata are latched on grant and held until l2_ready.
// Optional build macro: L2_ARB_RR_EN selects round-robin tie-break;
// without it L1D always wins a tie.
module l2_request_arbiter #(
  parameter int TAG_W  = 21,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i_read,
  input  logic [TAG_W-1:0]  req_i_tag,
  input  logic [IDX_W-1:0]  req_i_index,
  output logic              ready_i,
  input  logic              req_d_read,
  input  logic              req_d_write,
  input  logic [TAG_W-1:0]  req_d_tag,
  input  logic [IDX_W-1:0]  req_d_index,
  input  logic [DATA_W-1:0] req_d_wdata,
  output logic              ready_d,
  output logic              l2_read,
  output logic              l2_write,
  output logic [TAG_W-1:0]  l2_tag,
  output logic [IDX_W-1:0]  l2_index,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ready,
  output logic [1:0]        grant_o
);

  // State encoding doubles as the one-hot owner code on grant_o.
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_BUSY_I = 2'b01;
  localparam logic [1:0] S_BUSY_D = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  logic [1:0]        state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: most recent grant went to L1D
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic ri, rd, pick_d, grant_i, grant_d;

  // Arbitration between the two requesters; only consulted in IDLE.
  always_comb begin
    ri = req_i_read;
    rd = req_d_read | req_d_write;
`ifdef L2_ARB_RR_EN
    pick_d = ~last_d_q;
`else
    pick_d = 1'b1;
`endif
    grant_d = rd & (~ri | pick_d);
    grant_i = ri & ~grant_d;
  end

  // Next-state: IDLE -> BUSY_x on grant, BUSY_x -> DONE on l2_ready, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_i)      state_d = S_BUSY_I;
        else if (grant_d) state_d = S_BUSY_D;
      end
      S_BUSY_I, S_BUSY_D: if (l2_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch: capture on grant, drop the op when L2 completes.
  always_comb begin
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    tag_d      = tag_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    last_d_d   = last_d_q;
    if (state_q == S_IDLE) begin
      if (grant_i) begin
        l2_read_d  = 1'b1;
        l2_write_d = 1'b0;
        tag_d      = req_i_tag;
        index_d    = req_i_index;
        wdata_d    = '0;
        last_d_d   = 1'b0;
      end else if (grant_d) begin
        // A write-back wins over a concurrent refill; the refill re-arbitrates later.
        l2_read_d  = ~req_d_write;
        l2_write_d = req_d_write;
        tag_d      = req_d_tag;
        index_d    = req_d_index;
        wdata_d    = req_d_write ? req_d_wdata : '0;
        last_d_d   = 1'b1;
      end
    end else if ((state_q == S_BUSY_I || state_q == S_BUSY_D) && l2_ready) begin
      l2_read_d  = 1'b0;
      l2_write_d = 1'b0;
    end else if (state_q == S_DONE) begin
      l2_read_d  = 1'b0;
      l2_write_d = 1'b0;
    end
  end

  // State and latched request; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_d_q   <= 1'b1;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      tag_q      <= '0;
      index_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
      wdata_q    <= wdata_d;
    end
  end

  // Outputs: ready is a same-cycle pass-through of l2_ready gated by owner.
  always_comb begin
    ready_i = (state_q == S_BUSY_I) & l2_ready;
    ready_d = (state_q == S_BUSY_D) & l2_ready;
    grant_o = (state_q == S_BUSY_I || state_q == S_BUSY_D) ? state_q : 2'b00;
  end

  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign l2_tag   = tag_q;
  assign l2_index = index_q;
  assign l2_wdata = wdata_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: directed test-plan scenarios followed by
// random traffic, all checked against a transaction-owner model.
module tb_l2_request_arbiter;
  localparam int TAG_W = 21, IDX_W = 5, DATA_W = 128;

  logic clk = 1'b0, rst = 1'b1;
  logic req_i_read = 0, req_d_read = 0, req_d_write = 0, l2_ready = 0;
  logic [TAG_W-1:0]  req_i_tag = '0, req_d_tag = '0;
  logic [IDX_W-1:0]  req_i_index = '0, req_d_index = '0;
  logic [DATA_W-1:0] req_d_wdata = '0;
  logic ready_i, ready_d, l2_read, l2_write;
  logic [TAG_W-1:0]  l2_tag;
  logic [IDX_W-1:0]  l2_index;
  logic [DATA_W-1:0] l2_wdata;
  logic [1:0] grant_o;

  int n_chk = 0, n_err = 0;

  // Reference model: who owns L2 (0 none, 1 L1I, 2 L1D), cooldown flag, latched request.
  int m_owner;
  bit m_cool, m_last_d, m_read, m_write;
  logic [TAG_W-1:0]  m_tag;
  logic [IDX_W-1:0]  m_idx;
  logic [DATA_W-1:0] m_wdata;

  l2_request_arbiter #(.TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_i_read(req_i_read), .req_i_tag(req_i_tag), .req_i_index(req_i_index), .ready_i(ready_i),
    .req_d_read(req_d_read), .req_d_write(req_d_write), .req_d_tag(req_d_tag),
    .req_d_index(req_d_index), .req_d_wdata(req_d_wdata), .ready_d(ready_d),
    .l2_read(l2_read), .l2_write(l2_write), .l2_tag(l2_tag), .l2_index(l2_index),
    .l2_wdata(l2_wdata), .l2_ready(l2_ready), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cool = 0; m_last_d = 1; m_read = 0; m_write = 0;
    m_tag = '0; m_idx = '0; m_wdata = '0;
  endtask

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_edge();
    int win;
    if (rst) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (l2_ready) begin m_owner = 0; m_cool = 1; m_read = 0; m_write = 0; end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      win = 0;
      if (req_i_read && (req_d_read || req_d_write)) begin
`ifdef L2_ARB_RR_EN
        win = m_last_d ? 1 : 2;
`else
        win = 2;
`endif
      end else if (req_i_read) win = 1;
      else if (req_d_read || req_d_write) win = 2;
      if (win == 1) begin
        m_owner = 1; m_last_d = 0; m_read = 1; m_write = 0;
        m_tag = req_i_tag; m_idx = req_i_index; m_wdata = '0;
      end else if (win == 2) begin
        m_owner = 2; m_last_d = 1; m_write = req_d_write; m_read = !req_d_write;
        m_tag = req_d_tag; m_idx = req_d_index;
        m_wdata = req_d_write ? req_d_wdata : '0;
      end
    end
  endtask

  // Called just after a falling edge with inputs set: compare, then advance one cycle.
  task automatic step();
    #1;
    chk("l2_read",  l2_read,  m_read);
    chk("l2_write", l2_write, m_write);
    chk("l2_tag",   l2_tag,   m_tag);
    chk("l2_index", l2_index, m_idx);
    chk("l2_wdata", l2_wdata, m_wdata);
    chk("grant_o",  grant_o,  (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
    chk("ready_i",  ready_i,  (m_owner == 1) && l2_ready);
    chk("ready_d",  ready_d,  (m_owner == 2) && l2_ready);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_i_read = 0; req_d_read = 0; req_d_write = 0; l2_ready = 0;
  endtask

  initial begin
    logic [127:0] wb;
    wb = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_tag", l2_tag, 0);

    // Spurious ready in IDLE.
    l2_ready = 1;
    #1 chk("spur_ready_i", ready_i, 0);
    chk("spur_ready_d", ready_d, 0);
    step(); step();
    chk("spur_grant", grant_o, 2'b00);

    // I-only read: l2_ready 3 cycles after l2_read rises.
    idle_inputs();
    req_i_read = 1; req_i_tag = 21'h1ABCD; req_i_index = 5'h13;
    step(); step(); step(); step();
    chk("i_tag", l2_tag, 21'h1ABCD);
    chk("i_idx", l2_index, 5'h13);
    chk("i_grant", grant_o, 2'b01);
    l2_ready = 1;
    #1 chk("i_ready", ready_i, 1);
    step();
    l2_ready = 0;               // request still held through DONE
    step();
    req_i_read = 0;
    chk("i_no_regrant", grant_o, 2'b00);
    step(); step();

    // Simultaneous reads straight after reset.
    rst = 1; step(); rst = 0;
    req_i_read = 1; req_d_read = 1; req_d_tag = 21'h0F00D; req_d_index = 5'h07;
    step();
`ifdef L2_ARB_RR_EN
    chk("tie_first", grant_o, 2'b01);
`else
    chk("tie_first", grant_o, 2'b10);
`endif
    l2_ready = 1; step(); l2_ready = 0;
`ifdef L2_ARB_RR_EN
    req_i_read = 0;
`else
    req_d_read = 0;
`endif
    step();
    step();
`ifdef L2_ARB_RR_EN
    chk("tie_second", grant_o, 2'b10);
`else
    chk("tie_second", grant_o, 2'b01);
`endif
    l2_ready = 1; step(); idle_inputs(); step(); step();

    // D write-back plus refill.
    req_d_write = 1; req_d_read = 1; req_d_wdata = wb;
    step();
    chk("wb_write", l2_write, 1);
    chk("wb_read", l2_read, 0);
    chk("wb_data", l2_wdata, wb);
    l2_ready = 1; step(); l2_ready = 0;
    req_d_write = 0;
    step(); step();
    chk("rf_read", l2_read, 1);
    chk("rf_data", l2_wdata, 0);
    l2_ready = 1; step(); idle_inputs(); step(); step();

    // Reset in the middle of a D write.
    req_d_write = 1;
    step(); req_d_write = 0; step();
    chk("mid_write", l2_write, 1);
    rst = 1; step(); rst = 0;
    chk("mid_grant", grant_o, 2'b00);
    chk("mid_write0", l2_write, 0);
    l2_ready = 1;
    #1 chk("mid_no_ready", ready_d, 0);
    step(); l2_ready = 0;
    req_i_read = 1; req_i_tag = 21'h00123;
    step();
    chk("post_rst_grant", grant_o, 2'b01);
    l2_ready = 1; step(); idle_inputs(); step(); step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      req_i_read  = ($urandom_range(0, 9) < 6);
      req_d_read  = ($urandom_range(0, 9) < 5);
      req_d_write = ($urandom_range(0, 9) < 3);
      l2_ready    = ($urandom_range(0, 9) < 3);
      req_i_tag   = TAG_W'($urandom);
      req_d_tag   = TAG_W'($urandom);
      req_i_index = IDX_W'($urandom);
      req_d_index = IDX_W'($urandom);
      req_d_wdata = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
